// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit with HI/LO results.
// Define MULDIV_DIV_EN to build the divider; without it op=1 completes at once with zero results.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] pp, acc_sum;

  // Booth digit of the current triplet; the multiplicand register already carries the 2k shift
  always_comb begin
    pp = '0;
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = {mcand_q[2*WIDTH-2:0], 1'b0};
      3'b100:         pp = -{mcand_q[2*WIDTH-2:0], 1'b0};
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end
  assign acc_sum = acc_q + pp;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] abs_a, abs_b, rem_fix;
  logic [WIDTH:0]   rem_sh, rem_new;

  assign abs_a   = a[WIDTH-1] ? -a : a;
  assign abs_b   = b[WIDTH-1] ? -b : b;
  assign rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_new = rem_q[WIDTH] ? rem_sh + {1'b0, dvs_q} : rem_sh - {1'b0, dvs_q};
  assign rem_fix = rem_q[WIDTH-1:0] + (rem_q[WIDTH] ? dvs_q : '0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_DIV_EN
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          if (!op) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
            mplier_d = {b, 1'b0};
          end else begin
`ifdef MULDIV_DIV_EN
            if (b == '0) begin
              state_d = S_DONE;
              dbz_d   = 1'b1;
              hi_d    = a;
              lo_d    = '1;
            end else begin
              state_d   = S_DIV;
              cnt_d     = '0;
              rem_d     = '0;
              quo_d     = abs_a;
              dvs_d     = abs_b;
              neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem_d = a[WIDTH-1];
            end
`else
            state_d = S_DONE;
            hi_d    = '0;
            lo_d    = '0;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[2*WIDTH-3:0], 2'b00};
        mplier_d = {{2{mplier_q[WIDTH]}}, mplier_q[WIDTH:2]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          hi_d    = acc_sum[2*WIDTH-1:WIDTH];
          lo_d    = acc_sum[WIDTH-1:0];
        end
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        rem_d = rem_new;
        quo_d = {quo_q[WIDTH-2:0], ~rem_new[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        hi_d    = neg_rem_q ? -rem_fix : rem_fix;
        lo_d    = neg_quo_q ? -quo_q : quo_q;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_div;
  assign unused_div = &{1'b0, DIV_LAST};
`endif

  // Results land in hi/lo on entry to DONE, so busy drops while done is pulsed
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/flag/latency queued at issue, checked at done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] obs_hi, obs_lo;
  logic obs_dbz, obs_busy, obs_tail;
  int obs_lat;

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dbz = 1'b0;
    if (!o) begin
      p = sx * sy;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.lat = W / 2;
    end
`ifdef MULDIV_DIV_EN
    else if (y == '0) begin
      e.hi = x; e.lo = '1; e.dbz = 1'b1; e.lat = 0;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.hi = r[W-1:0]; e.lo = q[W-1:0]; e.lat = W + 1;
    end
`else
    else begin
      e.hi = '0; e.lo = '0; e.lat = 0;
    end
`endif
    return e;
  endfunction

  // Issue one op, optionally poke start mid-flight, and capture the result at the done cycle
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    obs_lat = 0;
    while (!done && obs_lat < 200) begin
      start = (poke && obs_lat == 3);
      @(posedge clk); #1;
      obs_lat++;
    end
    start = 1'b0;
    obs_hi = hi; obs_lo = lo; obs_dbz = dbz; obs_busy = busy;
    @(posedge clk); #1;
    obs_tail = done;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", dbz); end
    n_chk++; if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_chk++; if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_ops(input string name, input logic o, input logic [W-1:0] xs[], input logic [W-1:0] ys[]);
    exp_t e;
    for (int i = 0; i < xs.size(); i++) begin
      run_op(o, xs[i], ys[i], 1'b0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hi !== e.hi) begin n_fail++; $display("FAIL %s[%0d] hi got %h want %h", name, i, obs_hi, e.hi); end
      n_chk++; if (obs_lo !== e.lo) begin n_fail++; $display("FAIL %s[%0d] lo got %h want %h", name, i, obs_lo, e.lo); end
      n_chk++; if (obs_dbz !== e.dbz) begin n_fail++; $display("FAIL %s[%0d] dbz got %b want %b", name, i, obs_dbz, e.dbz); end
      n_chk++; if (obs_lat != e.lat) begin n_fail++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, obs_lat, e.lat); end
      n_chk++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL %s[%0d] busy_at_done got %b want 0", name, i, obs_busy); end
      n_chk++; if (obs_tail !== 1'b0) begin n_fail++; $display("FAIL %s[%0d] done_width got %b want 0", name, i, obs_tail); end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] xs[] = '{32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3, $urandom, $urandom, 32'hFFFF_FFFF};
    logic [W-1:0] ys[] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd4, $urandom, $urandom, 32'hFFFF_FFFF};
    test_ops("mul", 1'b0, xs, ys);
  endtask

  task automatic test_div();
    logic [W-1:0] xs[] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C, 32'd100, $urandom, 32'd3};
    logic [W-1:0] ys[] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'd12345, 32'd9};
    test_ops("div", 1'b1, xs, ys);
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] xs[] = '{32'd5};
    logic [W-1:0] ys[] = '{32'd0};
    logic [W-1:0] mx[] = '{32'd6};
    logic [W-1:0] my[] = '{32'd9};
    test_ops("dbz", 1'b1, xs, ys);
    test_ops("dbz_then_mul", 1'b0, mx, my);
  endtask

  task automatic test_ignore_start();
    exp_t e;
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (obs_hi !== e.hi) begin n_fail++; $display("FAIL ignore hi got %h want %h", obs_hi, e.hi); end
    n_chk++; if (obs_lo !== e.lo) begin n_fail++; $display("FAIL ignore lo got %h want %h", obs_lo, e.lo); end
    n_chk++; if (obs_lat != e.lat) begin n_fail++; $display("FAIL ignore latency got %0d want %0d", obs_lat, e.lat); end
    // no second done may follow from the poked start
    repeat (40) @(posedge clk);
    #1;
    n_chk++; if (hi !== e.hi || lo !== e.lo) begin n_fail++; $display("FAIL ignore_hold hi/lo got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle busy got %b want 0", busy); end
  endtask

  task automatic test_clr_abort();
    bit seen;
    logic [W-1:0] xs[] = '{32'd3};
    logic [W-1:0] ys[] = '{32'd4};
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %b want 0", busy); end
    n_chk++; if (hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL clr_hilo got %h/%h want 0/0", hi, lo); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL clr_done got %b want 0", done); end
    #3 clr = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clr_no_done got %b want 0", seen); end
    test_ops("clr_then_mul", 1'b0, xs, ys);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[] = '{32'd11, 32'hFFFF_FF00, 32'd0, 32'h1234_5678};
    logic [W-1:0] ys[] = '{32'd13, 32'd300, 32'h5555_5555, 32'h8765_4321};
    test_ops("b2b_mul", 1'b0, xs, ys);
    test_ops("b2b_div", 1'b1, xs, ys);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_clr_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
